// File: rtl/branch_predict_tracker_pkg.sv
// Shared definitions for the branch prediction tracker.
// Purpose : default sizes and the layout of one tracker entry.
// An entry is packed as {addr[LOWER-1:0], pred}. The prediction bit sits at
// bit 0 and the PC low bits fill the bits above it.
package branch_predict_tracker_pkg;

  localparam int LOWER_DEFAULT = 5;
  localparam int DEPTH_DEFAULT = 4;

  // Bit position of the predicted direction inside a packed entry.
  localparam int PRED_BIT = 0;

  // Width of one packed entry for a given address width.
  function automatic int entry_width(input int lower);
    return lower + 1;
  endfunction

endpackage

// File: rtl/branch_predict_tracker_if.sv
// Bus between fetch/execute and the branch prediction tracker.
// Purpose : bundles the push/resolve/flush controls and the BHT update,
//           status and error outputs.
// Modports: master - driven by the fetch/execute side
//           slave  - the tracker itself
interface branch_predict_tracker_if
  import branch_predict_tracker_pkg::*;
#(
  parameter int LOWER = LOWER_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [LOWER-1:0] push_addr;
  logic             push_pred;
  logic             resolve;
  logic             resolve_taken;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             upd_en;
  logic [LOWER-1:0] upd_addr;
  logic             upd_taken;
  logic             mispredict;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_addr, push_pred, resolve, resolve_taken, flush,
    input  full, empty, count, upd_en, upd_addr, upd_taken, mispredict,
           overflow, underflow
  );

  modport slave (
    input  push, push_addr, push_pred, resolve, resolve_taken, flush,
    output full, empty, count, upd_en, upd_addr, upd_taken, mispredict,
           overflow, underflow
  );

endinterface

// File: rtl/branch_predict_tracker_pred_fifo.sv
// pred_fifo: generic DEPTH x WIDTH circular buffer.
// Purpose : in-order store with push/pop/flush and occupancy tracking.
// Ports   : clk, arst_n (async active-low)
//           push/push_data - write request and data
//           pop            - read request; pop_data shows the head entry
//           flush          - clear pointers and count after the edge
//           count/full/empty - registered occupancy
//           pop_fire       - pop accepted this cycle (pop && !empty)
module pred_fifo
  import branch_predict_tracker_pkg::*;
#(
  parameter int WIDTH = entry_width(LOWER_DEFAULT),
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       pop_fire
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_fire;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_fire = pop && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly where
  // wr_ptr points, so the push can land there. A flush discards the push.
  assign push_fire = push && !flush && (!full || pop_fire);
  assign pop_data  = mem[rd_ptr_reg];

  // Storage is deliberately not reset; only the pointers define validity.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push_fire && (wr_ptr_reg == PW'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_tracker.sv
// branch_predict_tracker: in-order tracker of in-flight branch predictions.
// Purpose : records {PC low bits, predicted direction} at fetch, pops the
//           oldest record when execute resolves it and emits a registered
//           BHT update plus a one-cycle mispredict pulse.
// Ports   : clk    - rising-edge clock
//           arst_n - asynchronous active-low reset
//           bus    - slave side of branch_predict_tracker_if
//                    (push/resolve/flush in; status, update and sticky
//                    overflow/underflow flags out)
module branch_predict_tracker
  import branch_predict_tracker_pkg::*;
#(
  parameter int LOWER = LOWER_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      arst_n,
  branch_predict_tracker_if.slave   bus
);

  localparam int EW = entry_width(LOWER);

  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    pop_entry;
  logic             pop_fire;
  logic             pop_pred;
  logic [LOWER-1:0] pop_addr;

  logic             upd_en_reg;
  logic [LOWER-1:0] upd_addr_reg;
  logic             upd_taken_reg;
  logic             mispredict_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  assign push_entry = {bus.push_addr, bus.push_pred};
  assign pop_pred   = pop_entry[PRED_BIT];
  assign pop_addr   = pop_entry[EW-1 -: LOWER];

  pred_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (bus.push),
    .push_data (push_entry),
    .pop       (bus.resolve),
    .flush     (bus.flush),
    .pop_data  (pop_entry),
    .count     (bus.count),
    .full      (bus.full),
    .empty     (bus.empty),
    .pop_fire  (pop_fire)
  );

  // Update path: a valid pop (also in a flush cycle) produces one pulse.
  // Address and outcome hold their last value between pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_en_reg     <= 1'b0;
      upd_addr_reg   <= '0;
      upd_taken_reg  <= 1'b0;
      mispredict_reg <= 1'b0;
    end else begin
      upd_en_reg     <= pop_fire;
      mispredict_reg <= pop_fire && (pop_pred != bus.resolve_taken);
      if (pop_fire) begin
        upd_addr_reg  <= pop_addr;
        upd_taken_reg <= bus.resolve_taken;
      end
    end
  end

  // Sticky error flags. A push into a full buffer is only lost when no pop
  // frees a slot; a push discarded by flush is not an overflow.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.push && bus.full && !pop_fire && !bus.flush) overflow_reg <= 1'b1;
      if (bus.resolve && bus.empty) underflow_reg <= 1'b1;
    end
  end

  assign bus.upd_en     = upd_en_reg;
  assign bus.upd_addr   = upd_addr_reg;
  assign bus.upd_taken  = upd_taken_reg;
  assign bus.mispredict = mispredict_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.underflow  = underflow_reg;

endmodule

// File: tb/tb_branch_predict_tracker.sv
// Directed self-checking bench for branch_predict_tracker.
module tb_branch_predict_tracker;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_errors;

  branch_predict_tracker_if #(.LOWER(5), .DEPTH(4)) bus ();

  branch_predict_tracker #(.LOWER(5), .DEPTH(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [4:0] a, input logic pr,
                       input logic r, input logic t, input logic f);
    bus.push          = p;
    bus.push_addr     = a;
    bus.push_pred     = pr;
    bus.resolve       = r;
    bus.resolve_taken = t;
    bus.flush         = f;
  endtask

  task automatic idle();
    drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [3:0] taken_vec;
  logic [3:0] mis_vec;

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    arst_n = 1'b0;
    #12;
    check_val("rst_empty", {31'd0, bus.empty}, 32'd1);
    check_val("rst_full", {31'd0, bus.full}, 32'd0);
    check_val("rst_count", {29'd0, bus.count}, 32'd0);
    check_val("rst_upd_en", {31'd0, bus.upd_en}, 32'd0);
    check_val("rst_upd_addr", {27'd0, bus.upd_addr}, 32'd0);
    check_val("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    check_val("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check_val("rst_underflow", {31'd0, bus.underflow}, 32'd0);
    arst_n = 1'b1;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_state", {bus.empty, bus.full, bus.count, bus.upd_en,
                bus.mispredict, 26'd0}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 26'd0});
    end

    // Single push then mispredicted resolve.
    drive(1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("one_count", {29'd0, bus.count}, 32'd1);
    drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_val("one_upd_en", {31'd0, bus.upd_en}, 32'd1);
    check_val("one_upd_addr", {27'd0, bus.upd_addr}, 32'h10);
    check_val("one_upd_taken", {31'd0, bus.upd_taken}, 32'd0);
    check_val("one_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check_val("one_empty", {31'd0, bus.empty}, 32'd1);
    tick();
    check_val("one_pulse_end", {30'd0, bus.upd_en, bus.mispredict}, 32'd0);

    // Fill to full, then overflow.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), (i % 2 == 0), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_val("fill_full", {31'd0, bus.full}, 32'd1);
    check_val("fill_count", {29'd0, bus.count}, 32'd4);
    drive(1'b1, 5'h09, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    check_val("ovf_count", {29'd0, bus.count}, 32'd4);

    // Drain with taken = 0,1,1,1; preds 0,1,0,1.
    taken_vec = 4'b1110;
    mis_vec   = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'h00, 1'b0, 1'b1, taken_vec[i], 1'b0);
      tick();
      check_val("drain_upd_en", {31'd0, bus.upd_en}, 32'd1);
      check_val("drain_upd_addr", {27'd0, bus.upd_addr}, 32'(i + 1));
      check_val("drain_upd_taken", {31'd0, bus.upd_taken}, {31'd0, taken_vec[i]});
      check_val("drain_mispredict", {31'd0, bus.mispredict}, {31'd0, mis_vec[i]});
    end
    idle();
    tick();
    check_val("drain_done", {30'd0, bus.upd_en, bus.empty}, 32'd1);

    // Reset pulse clears sticky overflow.
    arst_n = 1'b0;
    #2;
    check_val("rst2_overflow", {31'd0, bus.overflow}, 32'd0);
    arst_n = 1'b1;
    tick();

    // Full with simultaneous push/resolve, then wrap-around.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(11 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_val("both_count", {29'd0, bus.count}, 32'd4);
    check_val("both_upd_addr", {27'd0, bus.upd_addr}, 32'd11);
    check_val("both_overflow", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_val("wrap_upd_addr", {27'd0, bus.upd_addr}, 32'(12 + i));
    end
    drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    check_val("wrap_last_addr", {27'd0, bus.upd_addr}, 32'd7);
    check_val("wrap_last_mis", {31'd0, bus.mispredict}, 32'd1);
    check_val("wrap_empty", {31'd0, bus.empty}, 32'd1);
    tick();

    // Flush with resolve and push in the same cycle at count 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(21 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_val("pre_flush_count", {29'd0, bus.count}, 32'd3);
    drive(1'b1, 5'h1e, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check_val("flush_upd_en", {31'd0, bus.upd_en}, 32'd1);
    check_val("flush_upd_addr", {27'd0, bus.upd_addr}, 32'd21);
    check_val("flush_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check_val("flush_count", {29'd0, bus.count}, 32'd0);
    check_val("flush_empty", {31'd0, bus.empty}, 32'd1);
    check_val("flush_overflow", {31'd0, bus.overflow}, 32'd0);
    tick();
    check_val("flush_push_gone", {29'd0, bus.count}, 32'd0);
    check_val("flush_pulse_end", {31'd0, bus.upd_en}, 32'd0);

    // Resolve while empty: sticky underflow, no update.
    drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    check_val("unf_upd_en", {31'd0, bus.upd_en}, 32'd0);
    check_val("unf_flag", {31'd0, bus.underflow}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check_val("unf_sticky", {31'd0, bus.underflow}, 32'd1);

    // Push and resolve while empty: push taken, resolve ignored.
    drive(1'b1, 5'h03, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_val("pe_count", {29'd0, bus.count}, 32'd1);
    check_val("pe_upd_en", {31'd0, bus.upd_en}, 32'd0);
    drive(1'b1, 5'h04, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    check_val("pe_upd_addr", {27'd0, bus.upd_addr}, 32'd3);
    check_val("pe_upd_en2", {31'd0, bus.upd_en}, 32'd1);
    check_val("pe_count2", {29'd0, bus.count}, 32'd1);

    // Asynchronous reset while an update pulse is being presented.
    #1;
    arst_n = 1'b0;
    #1;
    check_val("arst_upd", {28'd0, bus.upd_en, bus.mispredict, bus.upd_taken,
              bus.overflow}, 32'd0);
    check_val("arst_upd_addr", {27'd0, bus.upd_addr}, 32'd0);
    check_val("arst_count", {29'd0, bus.count}, 32'd0);
    check_val("arst_empty", {31'd0, bus.empty}, 32'd1);
    check_val("arst_underflow", {31'd0, bus.underflow}, 32'd0);
    arst_n = 1'b1;
    tick();
    check_val("post_arst", {30'd0, bus.empty, bus.upd_en}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
